// File: rtl/horner_pkg.sv
// Shared constants, reset defaults and the saturation helper for the Horner
// polynomial pipeline. All arithmetic values are signed Q16 in 32 bits.
package horner_pkg;

  localparam int unsigned QW = 32;

  localparam logic [QW-1:0] Q16_ONE = 32'd65536;
  localparam logic [QW-1:0] Q16_RND = 32'd32768;
  localparam logic [QW-1:0] Q_MAX   = 32'h7FFF_FFFF;
  localparam logic [QW-1:0] Q_MIN   = 32'h8000_0000;

  // Default 7th-order cutoff kernel, c_7 in the MSBs down to c_0.
  localparam int unsigned DEF_DEGREE = 7;
  localparam logic [(DEF_DEGREE+1)*QW-1:0] COEF_INIT_DEF = {
    32'd1198,       // c_7
    32'd0,          // c_6
    32'hFFFF_C0E5,  // c_5 = -16155
    32'd0,          // c_4
    32'd116719,     // c_3
    32'hFFFD_93EE,  // c_2 = -158738
    32'd0,          // c_1
    Q16_ONE         // c_0
  };
  localparam logic [QW-1:0] CUTOFF_INIT_DEF = 32'd111411;

  typedef struct packed {
    logic          sat;
    logic [QW-1:0] val;
  } q_res_t;

  // Clamp a 33-bit signed value into 32-bit signed, flagging the clamp.
  function automatic q_res_t sat32(input logic signed [QW:0] x);
    q_res_t res;
    res.sat = 1'b0;
    res.val = x[QW-1:0];
    if (x[QW] != x[QW-1]) begin
      res.sat = 1'b1;
      res.val = x[QW] ? Q_MIN : Q_MAX;
    end
    return res;
  endfunction

endpackage

// File: rtl/horner_poly_step.sv
// horner_step: one combinational Horner step, nxt = sadd(smul(acc, r), coef).
// Ports: acc (signed Q16), r (unsigned Q16), coef (signed Q16),
//        nxt (signed Q16 result), sat (either operation clamped).
module horner_step
  import horner_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic [QW-1:0]         acc,
  input  logic [DATA_WIDTH-1:0] r,
  input  logic [QW-1:0]         coef,
  output logic [QW-1:0]         nxt,
  output logic                  sat
);

  logic signed [QW:0]     r_s;
  logic signed [2*QW:0]   prod;
  logic signed [2*QW:0]   shifted;
  logic [QW-1:0]          mul_val;
  logic                   mul_sat;
  q_res_t                 add_res;

  always_comb begin
    // r is unsigned, so widening zero-extends before the signed multiply.
    r_s     = 33'(r);
    prod    = 65'($signed(acc)) * 65'(r_s);
    // Round half up, then drop the 16 fractional bits of the product.
    shifted = (prod + 65'($signed(Q16_RND))) >>> 16;
    // In range only if bits 64..31 are all copies of the sign.
    mul_sat = !((&shifted[2*QW:QW-1]) || !(|shifted[2*QW:QW-1]));
    mul_val = shifted[QW-1:0];
    if (mul_sat) begin
      mul_val = shifted[2*QW] ? Q_MIN : Q_MAX;
    end
    add_res = sat32(33'($signed(mul_val)) + 33'($signed(coef)));
    nxt     = add_res.val;
    sat     = mul_sat | add_res.sat;
  end

endmodule

// File: rtl/horner_poly_pipe.sv
// horner_poly_pipe: fully pipelined Horner evaluator of a programmable
// polynomial f(r) = sum c_k r^k in Q16, forced to 0 beyond a cutoff.
// Ports: clk/rst (async active-high), in_valid/in_ready/in_r input stream,
//        out_valid/out_ready/out_f/out_sat result stream, cfg_we/cfg_addr/
//        cfg_wdata config port with cfg_err reject pulse, idle indicator.
module horner_poly_pipe
  import horner_pkg::*;
#(
  parameter int unsigned DATA_WIDTH             = 16,
  parameter int unsigned DEGREE                 = 7,
  parameter logic [(DEGREE+1)*QW-1:0] COEF_INIT = COEF_INIT_DEF,
  parameter logic [QW-1:0] CUTOFF_INIT          = CUTOFF_INIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_r,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QW-1:0]         out_f,
  output logic                  out_sat,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_addr,
  input  logic [QW-1:0]         cfg_wdata,
  output logic                  cfg_err,
  output logic                  idle
);

  localparam int unsigned N  = DEGREE;
  localparam int unsigned CW = (N + 1 > 1) ? $clog2(N + 1) : 1;

  // Stage k holds the sample after k Horner steps (stage 0 = capture).
  logic [DATA_WIDTH-1:0] r_q   [0:N-1];
  logic [DATA_WIDTH-1:0] r_d   [0:N-1];
  logic [QW-1:0]         acc_q [0:N-1];
  logic [QW-1:0]         acc_d [0:N-1];
  logic [N-1:0]          v_q, v_d;
  logic [N-1:0]          sat_q, sat_d;
  logic [N-1:0]          gt_q, gt_d;

  logic [QW-1:0]         coef_q [0:N];
  logic [QW-1:0]         coef_d [0:N];
  logic [QW-1:0]         cutoff_q, cutoff_d;

  logic                  out_valid_q, out_valid_d;
  logic [QW-1:0]         out_f_q, out_f_d;
  logic                  out_sat_q, out_sat_d;
  logic                  cfg_err_q, cfg_err_d;

  logic [QW-1:0]         nxt_w [1:N];
  logic [N:1]            sat_w;

  logic                  adv;
  logic                  accept;
  logic                  cfg_ok;

  // Step k consumes stage k-1 and folds in coefficient c_{N-k}.
  for (genvar k = 1; k <= N; k++) begin : g_step
    horner_step #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
      .acc (acc_q[k-1]),
      .r   (r_q[k-1]),
      .coef(coef_q[N-k]),
      .nxt (nxt_w[k]),
      .sat (sat_w[k])
    );
  end

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv && !cfg_we;
  assign accept    = in_valid && in_ready;
  assign idle      = !(|v_q) && !out_valid_q;
  assign out_valid = out_valid_q;
  assign out_f     = out_f_q;
  assign out_sat   = out_sat_q;
  assign cfg_err   = cfg_err_q;

  // Next-state for pipeline, output stage and configuration.
  always_comb begin
    r_d         = r_q;
    acc_d       = acc_q;
    v_d         = v_q;
    sat_d       = sat_q;
    gt_d        = gt_q;
    coef_d      = coef_q;
    cutoff_d    = cutoff_q;
    out_valid_d = out_valid_q;
    out_f_d     = out_f_q;
    out_sat_d   = out_sat_q;
    cfg_err_d   = 1'b0;
    cfg_ok      = idle && (5'(cfg_addr) <= 5'(N + 1));

    if (adv) begin
      v_d[0] = accept;
      if (accept) begin
        r_d[0]   = in_r;
        acc_d[0] = coef_q[N];
        sat_d[0] = 1'b0;
        gt_d[0]  = 32'(in_r) > cutoff_q;
      end
      for (int unsigned k = 1; k < N; k++) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) begin
          r_d[k]   = r_q[k-1];
          acc_d[k] = nxt_w[k];
          sat_d[k] = sat_q[k-1] | sat_w[k];
          gt_d[k]  = gt_q[k-1];
        end
      end
      out_valid_d = v_q[N-1];
      if (v_q[N-1]) begin
        out_f_d   = gt_q[N-1] ? '0 : nxt_w[N];
        out_sat_d = sat_q[N-1] | sat_w[N];
      end
    end

    // Writes only land while nothing is in flight.
    if (cfg_we) begin
      cfg_err_d = !cfg_ok;
      if (cfg_ok) begin
        if (5'(cfg_addr) == 5'(N + 1)) begin
          cutoff_d = cfg_wdata;
        end else begin
          coef_d[CW'(cfg_addr)] = cfg_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      sat_q <= '0;
      gt_q  <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        r_q[k]   <= '0;
        acc_q[k] <= '0;
      end
      for (int unsigned k = 0; k <= N; k++) begin
        coef_q[k] <= COEF_INIT[k*QW +: QW];
      end
      cutoff_q    <= CUTOFF_INIT;
      out_valid_q <= 1'b0;
      out_f_q     <= '0;
      out_sat_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      v_q         <= v_d;
      sat_q       <= sat_d;
      gt_q        <= gt_d;
      r_q         <= r_d;
      acc_q       <= acc_d;
      coef_q      <= coef_d;
      cutoff_q    <= cutoff_d;
      out_valid_q <= out_valid_d;
      out_f_q     <= out_f_d;
      out_sat_q   <= out_sat_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_horner_poly_pipe.sv
// Self-checking bench for horner_poly_pipe: arithmetic reference model with
// scoreboard, per-cycle protocol checks and directed literal expectations.
module tb_horner_poly_pipe;

  localparam int unsigned DW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_r = '0;
  logic          out_ready = 1'b1;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_addr = '0;
  logic [31:0]   cfg_wdata = '0;
  logic          in_ready, out_valid, out_sat, cfg_err, idle;
  logic [31:0]   out_f;

  horner_poly_pipe #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_sat(out_sat),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_err(cfg_err), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] f;
    logic        sat;
  } exp_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  exp_t        q[$];
  int          m_coef[8];
  logic [31:0] m_cutoff;
  logic [31:0] last_f = '0;
  logic        last_sat = 1'b0;
  int          n_out = 0;
  bit          rdy_rand = 1'b0;
  bit          pend_err = 1'b0;
  bit          prev_stall = 1'b0;
  bit          cfg_ok_m;
  logic [31:0] prev_f;
  logic        prev_sat;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_mirror();
    m_coef   = '{65536, 0, -158738, 116719, 0, -16155, 0, 1198};
    m_cutoff = 32'd111411;
  endtask

  function automatic longint clamp32(input longint v, inout bit s);
    if (v > 64'sd2147483647) begin
      s = 1'b1;
      return 64'sd2147483647;
    end
    if (v < -64'sd2147483648) begin
      s = 1'b1;
      return -64'sd2147483648;
    end
    return v;
  endfunction

  // f(r) by Horner with rounded Q16 products and saturation at every op.
  function automatic exp_t model(input longint r);
    exp_t   e;
    longint acc;
    bit     s;
    s   = 1'b0;
    acc = longint'(m_coef[7]);
    for (int k = 6; k >= 0; k--) begin
      acc = clamp32((acc * r + 64'sd32768) >>> 16, s);
      acc = clamp32(acc + longint'(m_coef[k]), s);
    end
    e.f   = (r > longint'(m_cutoff)) ? 32'd0 : 32'(acc);
    e.sat = s;
    return e;
  endfunction

  // Compare process: everything refers to the upcoming rising edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      reset_mirror();
      pend_err   = 1'b0;
      prev_stall = 1'b0;
      chk("out_valid_in_reset", longint'(out_valid), 0);
    end else begin
      chk("cfg_err", longint'(cfg_err), longint'(pend_err));
      chk("idle", longint'(idle), longint'(q.size() == 0));
      if (out_valid && !out_ready) chk("in_ready_stall", longint'(in_ready), 0);
      if (cfg_we) chk("in_ready_cfg", longint'(in_ready), 0);
      if (prev_stall) begin
        chk("hold_valid", longint'(out_valid), 1);
        chk("hold_f", longint'($signed(out_f)), longint'($signed(prev_f)));
        chk("hold_sat", longint'(out_sat), longint'(prev_sat));
      end
      pend_err = 1'b0;
      if (cfg_we) begin
        cfg_ok_m = (q.size() == 0) && (cfg_addr <= 4'd8);
        pend_err = !cfg_ok_m;
        if (cfg_ok_m) begin
          if (cfg_addr == 4'd8) m_cutoff = cfg_wdata;
          else m_coef[cfg_addr] = int'($signed(cfg_wdata));
        end
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_output", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_f", longint'($signed(out_f)), longint'($signed(e.f)));
          chk("out_sat", longint'(out_sat), longint'(e.sat));
        end
        last_f   = out_f;
        last_sat = out_sat;
        n_out++;
      end
      if (in_valid && in_ready) q.push_back(model(longint'(in_r)));
      prev_stall = out_valid && !out_ready;
      prev_f     = out_f;
      prev_sat   = out_sat;
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = rdy_rand ? ($urandom_range(0, 9) >= 3) : 1'b1;
  end

  // Leaves in_valid high so consecutive calls stream back-to-back.
  task automatic send(input logic [DW-1:0] r);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    in_valid = 1'b1;
    in_r = r;
    while (!got && n < 200) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) chk("send_timeout", 0, 1);
  endtask

  task automatic send_one(input logic [DW-1:0] r);
    send(r);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 2000) begin
      @(negedge clk);
      done = idle && (q.size() == 0);
      n++;
    end
    if (!done) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d, output bit err);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    err = cfg_err;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n0;
    bit err;
    reset_mirror();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_f", longint'(out_f), 0);
    chk("rst_out_sat", longint'(out_sat), 0);
    chk("rst_cfg_err", longint'(cfg_err), 0);
    chk("rst_idle", longint'(idle), 1);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;

    // r = 0 gives c_0 after exactly 7 cycles.
    send_one('0);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
    end
    chk("latency", lat, 7);
    wait_idle();
    chk("r0_f", longint'($signed(last_f)), 65536);
    chk("r0_sat", longint'(last_sat), 0);

    // r = 1.0 gives the coefficient sum; beyond cutoff gives 0.
    send_one(20'd65536);
    wait_idle();
    chk("r1_f", longint'($signed(last_f)), 8560);
    send_one(20'd131072);
    wait_idle();
    chk("r2_gt_f", longint'($signed(last_f)), 0);
    send_one(20'd111411);
    wait_idle();
    send_one(20'd111412);
    wait_idle();
    chk("cutoff_plus1_f", longint'($signed(last_f)), 0);
    send_one(20'd1048575);
    wait_idle();
    chk("big_r_f", longint'($signed(last_f)), 0);
    chk("big_r_sat", longint'(last_sat), 1);

    // Random stream under backpressure.
    n0 = n_out;
    rdy_rand = 1'b1;
    for (int i = 0; i < 20; i++) send(DW'($urandom_range(0, 111410)));
    in_valid = 1'b0;
    wait_idle();
    rdy_rand = 1'b0;
    chk("stream_count", n_out - n0, 20);

    // Write while busy is rejected; write while idle lands.
    send_one(20'd65536);
    cfg_write(4'd0, 32'd0, err);
    chk("cfg_err_busy", longint'(err), 1);
    wait_idle();
    chk("busy_sample_f", longint'($signed(last_f)), 8560);
    send_one('0);
    wait_idle();
    chk("after_reject_f", longint'($signed(last_f)), 65536);
    cfg_write(4'd12, 32'd5, err);
    chk("cfg_err_addr", longint'(err), 1);
    cfg_write(4'd0, 32'd0, err);
    chk("cfg_err_idle", longint'(err), 0);
    send_one('0);
    wait_idle();
    chk("c0_zero_f", longint'($signed(last_f)), 0);

    // Reset with samples in flight.
    for (int i = 0; i < 4; i++) send(DW'(20'd1000 * (i + 1)));
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_valid", longint'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_idle", longint'(idle), 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n0 = n_out;
    repeat (10) @(posedge clk);
    #1;
    chk("no_stale", n_out - n0, 0);
    send_one('0);
    wait_idle();
    chk("restored_f", longint'($signed(last_f)), 65536);
    chk("restored_count", n_out - n0, 1);

    // Saturating case with raised cutoff and c_7.
    cfg_write(4'd8, 32'h7FFF_FFFF, err);
    chk("cfg_cutoff_err", longint'(err), 0);
    cfg_write(4'd7, 32'h7FFF_FFFF, err);
    chk("cfg_c7_err", longint'(err), 0);
    send_one(20'd262144);
    wait_idle();
    chk("sat_f", longint'($signed(last_f)), 2147483647);
    chk("sat_flag", longint'(last_sat), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
